// File: rtl/frame_load_writer_if.sv
// Bundles the pixel-stream, frame-memory write and done/ack handshake
// signals exchanged between the frame loader and its neighbours.
interface frame_load_writer_if #(
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 17
);
   logic              in_valid;
   logic              in_ready;
   logic [PIX_W-1:0]  in_data;
   logic              in_sof;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_wdata;
   logic              done;
   logic              done_ack;
   logic              frame_err;
   logic [7:0]        frame_cnt;

   // The writer itself: consumes the stream and ack, drives memory and status.
   modport slave (
      input  in_valid, in_data, in_sof, done_ack,
      output in_ready, mem_we, mem_addr, mem_wdata, done, frame_err, frame_cnt
   );

   modport master (
      output in_valid, in_data, in_sof, done_ack,
      input  in_ready, mem_we, mem_addr, mem_wdata, done, frame_err, frame_cnt
   );
endinterface

// File: rtl/frame_load_writer.sv
// Loads one complete row-major frame from a valid/ready pixel stream into
// frame memory and holds done until the downstream stage acknowledges it.
module frame_load_writer #(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 17
) (
   input logic                  clk,
   input logic                  reset,
   frame_load_writer_if.slave   bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] cnt_d;
   logic              in_ready_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [PIX_W-1:0]  mem_wdata_q;
   logic              done_q;
   logic              frame_err_q;
   logic [7:0]        frame_cnt_q;
   logic              accept;

   assign accept = bus.in_valid && in_ready_q;
   assign cnt_d  = cnt_q + ADDR_W'(1);

   // An in_sof beat always restarts at address 0, even on what would have
   // been the final pixel, so a truncated frame can never raise done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         mem_we_q    <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (accept && bus.in_sof) begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= bus.in_data;
                  cnt_q       <= ADDR_W'(1);
                  if (LAST_ADDR == '0) begin
                     state_q    <= FLUSH;
                     in_ready_q <= 1'b0;
                  end else begin
                     state_q <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  mem_we_q    <= 1'b1;
                  mem_wdata_q <= bus.in_data;
                  if (bus.in_sof) begin
                     mem_addr_q  <= '0;
                     cnt_q       <= ADDR_W'(1);
                     frame_err_q <= 1'b1;
                  end else begin
                     mem_addr_q <= cnt_q;
                     if (cnt_q == LAST_ADDR) begin
                        state_q    <= FLUSH;
                        in_ready_q <= 1'b0;
                     end else begin
                        cnt_q <= cnt_d;
                     end
                  end
               end
            end
            FLUSH: begin
               in_ready_q  <= 1'b0;
               state_q     <= DONE;
               done_q      <= 1'b1;
               frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            DONE: begin
               if (bus.done_ack) begin
                  state_q    <= IDLE;
                  done_q     <= 1'b0;
                  in_ready_q <= 1'b1;
                  cnt_q      <= '0;
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.done      = done_q;
   assign bus.frame_err = frame_err_q;
   assign bus.frame_cnt = frame_cnt_q;

endmodule
